// File: rtl/rename_freelist_if.sv
// Rename-stage free-list port bundle: allocation request/response, commit-dealloc
// return path, commit accounting and squash.
interface rename_freelist_if #(
  parameter int WIDTH      = 4,
  parameter int COMMIT_WID = 4,
  parameter int NUM_PHYREG = 128,
  parameter int PR_W       = $clog2(NUM_PHYREG)
);
  logic [WIDTH-1:0]                 i_req_vld;
  logic                             i_alloc_fire;
  logic                             o_can_alloc;
  logic [WIDTH-1:0][PR_W-1:0]       o_alloc_prd_idx;
  logic [COMMIT_WID-1:0]            i_dealloc_vld;
  logic [COMMIT_WID-1:0][PR_W-1:0]  i_dealloc_prd_idx;
  logic [COMMIT_WID-1:0]            i_commit_vld;
  logic [COMMIT_WID-1:0]            i_commit_alloc;
  logic                             i_squash_vld;
  logic [PR_W:0]                    o_free_cnt;

  modport master (
    output i_req_vld, i_alloc_fire, i_dealloc_vld, i_dealloc_prd_idx,
           i_commit_vld, i_commit_alloc, i_squash_vld,
    input  o_can_alloc, o_alloc_prd_idx, o_free_cnt
  );

  modport slave (
    input  i_req_vld, i_alloc_fire, i_dealloc_vld, i_dealloc_prd_idx,
           i_commit_vld, i_commit_alloc, i_squash_vld,
    output o_can_alloc, o_alloc_prd_idx, o_free_cnt
  );
endinterface

// File: rtl/rename_freelist.sv
// Physical-register free list: circular array with speculative head, committed
// (arch) head and tail. Squash restores the speculative head from the arch head.
module rename_freelist #(
  parameter int WIDTH      = 4,
  parameter int COMMIT_WID = 4,
  parameter int NUM_PHYREG = 128,
  parameter int PR_W       = $clog2(NUM_PHYREG)
) (
  input  logic             clk,
  input  logic             rst,
  rename_freelist_if.slave fl
);
  localparam int PTR_W = PR_W + 1;

  logic [PR_W-1:0]  r_entry [NUM_PHYREG];
  logic [PTR_W-1:0] r_spec_head;
  logic [PTR_W-1:0] r_arch_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W-1:0] r_free_cnt;

  logic [PTR_W-1:0]             w_req_n;
  logic [WIDTH-1:0][PR_W-1:0]   w_rd_addr;
  logic [WIDTH-1:0][PR_W-1:0]   w_alloc_idx;
  logic [PTR_W-1:0]             w_dealloc_n;
  logic [COMMIT_WID-1:0][PR_W-1:0] w_wr_addr;
  logic [PTR_W-1:0]             w_commit_n;
  logic                         w_dealloc_zero;
  logic                         w_can_alloc;
  logic                         w_alloc_go;
  logic [PTR_W-1:0]             w_spec_head_nxt;
  logic [PTR_W-1:0]             w_arch_head_nxt;
  logic [PTR_W-1:0]             w_tail_nxt;

  // Each requesting slot reads the entry offset by the number of earlier requesters.
  always_comb begin
    w_req_n     = '0;
    w_rd_addr   = '0;
    w_alloc_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_rd_addr[i] = r_spec_head[PR_W-1:0] + w_req_n[PR_W-1:0];
      if (fl.i_req_vld[i]) begin
        w_alloc_idx[i] = r_entry[w_rd_addr[i]];
      end
      w_req_n = w_req_n + {{PR_W{1'b0}}, fl.i_req_vld[i]};
    end
  end

  // Released indices are compacted in lane order onto the tail.
  always_comb begin
    w_dealloc_n    = '0;
    w_wr_addr      = '0;
    w_dealloc_zero = 1'b0;
    for (int j = 0; j < COMMIT_WID; j++) begin
      w_wr_addr[j] = r_tail[PR_W-1:0] + w_dealloc_n[PR_W-1:0];
      if (fl.i_dealloc_vld[j] && (fl.i_dealloc_prd_idx[j] == '0)) begin
        w_dealloc_zero = 1'b1;
      end
      w_dealloc_n = w_dealloc_n + {{PR_W{1'b0}}, fl.i_dealloc_vld[j]};
    end
  end

  always_comb begin
    w_commit_n = '0;
    for (int j = 0; j < COMMIT_WID; j++) begin
      w_commit_n = w_commit_n + {{PR_W{1'b0}}, (fl.i_commit_vld[j] & fl.i_commit_alloc[j])};
    end
  end

  assign w_can_alloc     = !fl.i_squash_vld && (r_free_cnt >= w_req_n);
  assign w_alloc_go      = fl.i_alloc_fire && w_can_alloc;
  assign w_arch_head_nxt = r_arch_head + w_commit_n;
  assign w_tail_nxt      = r_tail + w_dealloc_n;

  // Squash lands on the arch head including this cycle's commits.
  always_comb begin
    w_spec_head_nxt = r_spec_head;
    if (fl.i_squash_vld) begin
      w_spec_head_nxt = w_arch_head_nxt;
    end else if (w_alloc_go) begin
      w_spec_head_nxt = r_spec_head + w_req_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_spec_head <= '0;
      r_arch_head <= '0;
      r_tail      <= PTR_W'(NUM_PHYREG - 1);
      r_free_cnt  <= PTR_W'(NUM_PHYREG - 1);
      for (int k = 0; k < NUM_PHYREG; k++) begin
        r_entry[k] <= (k == NUM_PHYREG - 1) ? '0 : PR_W'(k + 1);
      end
    end else begin
      r_spec_head <= w_spec_head_nxt;
      r_arch_head <= w_arch_head_nxt;
      r_tail      <= w_tail_nxt;
      r_free_cnt  <= w_tail_nxt - w_spec_head_nxt;
      for (int j = 0; j < COMMIT_WID; j++) begin
        if (fl.i_dealloc_vld[j]) begin
          r_entry[w_wr_addr[j]] <= fl.i_dealloc_prd_idx[j];
        end
      end
    end
  end

  assign fl.o_can_alloc     = w_can_alloc;
  assign fl.o_alloc_prd_idx = w_alloc_idx;
  assign fl.o_free_cnt      = r_free_cnt;

  a_no_blocked_fire: assert property (@(posedge clk) disable iff (rst)
    !(fl.i_alloc_fire && !w_can_alloc));
  a_no_dealloc_zero: assert property (@(posedge clk) disable iff (rst)
    !w_dealloc_zero);
  a_free_cnt_max: assert property (@(posedge clk) disable iff (rst)
    r_free_cnt <= PTR_W'(NUM_PHYREG - 1));
  a_arch_behind_spec: assert property (@(posedge clk) disable iff (rst)
    (r_spec_head - r_arch_head) <= PTR_W'(NUM_PHYREG));
endmodule

// File: tb/tb_rename_freelist.sv
// Directed vector table plus hand sequences (exhaust, squash, reset, sparse) and a
// queue-modelled random alloc/dealloc/commit run that wraps the pointers.
module tb_rename_freelist;
  localparam int WIDTH = 4, COMMIT_WID = 4, NUM_PHYREG = 128, PR_W = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rename_freelist_if #(.WIDTH(WIDTH), .COMMIT_WID(COMMIT_WID), .NUM_PHYREG(NUM_PHYREG), .PR_W(PR_W)) fl ();
  rename_freelist #(.WIDTH(WIDTH), .COMMIT_WID(COMMIT_WID), .NUM_PHYREG(NUM_PHYREG), .PR_W(PR_W))
    dut (.clk(clk), .rst(rst), .fl(fl));

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [3:0]  req;
    logic        fire;
    logic [3:0]  dvld;
    logic [27:0] didx;
    logic [3:0]  cvld;
    logic [3:0]  calloc;
    logic        sq;
    logic        exp_can;
    logic [27:0] exp_idx;
    logic [7:0]  exp_free;
  } vec_t;

  vec_t vq[$];

  function automatic logic [27:0] p4(input int a, input int b, input int c, input int d);
    return {7'(d), 7'(c), 7'(b), 7'(a)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Drive one cycle at the falling edge; outputs are sampled 1 time unit later.
  task automatic cyc(input logic [3:0] req, input logic fire, input logic [3:0] dvld,
                     input logic [27:0] didx, input logic [3:0] cvld, input logic [3:0] calloc,
                     input logic sq);
    @(negedge clk);
    rst                  = 1'b0;
    fl.i_req_vld         = req;
    fl.i_alloc_fire      = fire;
    fl.i_dealloc_vld     = dvld;
    fl.i_dealloc_prd_idx = didx;
    fl.i_commit_vld      = cvld;
    fl.i_commit_alloc    = calloc;
    fl.i_squash_vld      = sq;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst                  = 1'b1;
    fl.i_req_vld         = '0;
    fl.i_alloc_fire      = 1'b0;
    fl.i_dealloc_vld     = '0;
    fl.i_dealloc_prd_idx = '0;
    fl.i_commit_vld      = '0;
    fl.i_commit_alloc    = '0;
    fl.i_squash_vld      = 1'b0;
    @(negedge clk);
  endtask

  int          q[$];
  int          outq[$];
  int          pend, rn, nd, k, taken, ofs, pick;
  logic [3:0]  r_req, r_dvld, r_cmask, r_cvld;
  logic        r_fire, mcan, saw_zero;
  logic [27:0] r_didx, r_exp;
  int          dv[$];

  initial begin
    fl.i_req_vld = '0; fl.i_alloc_fire = 1'b0; fl.i_dealloc_vld = '0;
    fl.i_dealloc_prd_idx = '0; fl.i_commit_vld = '0; fl.i_commit_alloc = '0;
    fl.i_squash_vld = 1'b0;

    //            req    fire dvld   didx             cvld   calloc sq  can  exp_idx          free
    vq.push_back('{4'hF, 1'b1, 4'h0, '0,              4'h0, 4'h0, 1'b0, 1'b1, p4(1,2,3,4),     8'd127});
    vq.push_back('{4'hF, 1'b0, 4'h0, '0,              4'h0, 4'h0, 1'b0, 1'b1, p4(5,6,7,8),     8'd123});
    vq.push_back('{4'hA, 1'b1, 4'h0, '0,              4'h0, 4'h0, 1'b0, 1'b1, p4(0,5,0,6),     8'd123});
    vq.push_back('{4'h0, 1'b1, 4'h0, '0,              4'h0, 4'h0, 1'b0, 1'b1, p4(0,0,0,0),     8'd121});
    vq.push_back('{4'h0, 1'b0, 4'h5, p4(5,0,6,0),     4'h0, 4'h0, 1'b0, 1'b1, p4(0,0,0,0),     8'd121});
    vq.push_back('{4'h1, 1'b1, 4'h0, '0,              4'hF, 4'h3, 1'b0, 1'b1, p4(7,0,0,0),     8'd123});
    vq.push_back('{4'h0, 1'b0, 4'h0, '0,              4'h1, 4'h1, 1'b1, 1'b0, p4(0,0,0,0),     8'd122});
    vq.push_back('{4'hF, 1'b1, 4'h0, '0,              4'h0, 4'h0, 1'b0, 1'b1, p4(4,5,6,7),     8'd126});
    vq.push_back('{4'h3, 1'b0, 4'h0, '0,              4'h0, 4'h0, 1'b1, 1'b0, p4(8,9,0,0),     8'd122});
    vq.push_back('{4'hF, 1'b0, 4'h0, '0,              4'h0, 4'h0, 1'b0, 1'b1, p4(4,5,6,7),     8'd126});
    vq.push_back('{4'h7, 1'b1, 4'hA, p4(0,1,0,2),     4'h6, 4'h4, 1'b0, 1'b1, p4(4,5,6,0),     8'd126});
    vq.push_back('{4'hF, 1'b0, 4'h0, '0,              4'h0, 4'h0, 1'b0, 1'b1, p4(7,8,9,10),    8'd125});

    do_reset();
    for (int i = 0; i < vq.size(); i++) begin
      cyc(vq[i].req, vq[i].fire, vq[i].dvld, vq[i].didx, vq[i].cvld, vq[i].calloc, vq[i].sq);
      chk($sformatf("v%0d_can", i),  {31'd0, fl.o_can_alloc}, {31'd0, vq[i].exp_can});
      chk($sformatf("v%0d_idx", i),  {4'd0, fl.o_alloc_prd_idx}, {4'd0, vq[i].exp_idx});
      chk($sformatf("v%0d_free", i), {24'd0, fl.o_free_cnt}, {24'd0, vq[i].exp_free});
    end

    // Exhaust: drain to 2 free, a 3-request must be refused, then refill via dealloc.
    do_reset();
    for (int i = 0; i < 31; i++) cyc(4'hF, 1'b1, 4'h0, '0, 4'h0, 4'h0, 1'b0);
    cyc(4'h1, 1'b1, 4'h0, '0, 4'h0, 4'h0, 1'b0);
    cyc(4'h7, 1'b0, 4'h0, '0, 4'h0, 4'h0, 1'b0);
    chk("exh_can0", {31'd0, fl.o_can_alloc}, 32'd0);
    chk("exh_free2", {24'd0, fl.o_free_cnt}, 32'd2);
    cyc(4'h0, 1'b0, 4'h5, p4(9,0,10,0), 4'h0, 4'h0, 1'b0);
    chk("exh_hold", {24'd0, fl.o_free_cnt}, 32'd2);
    cyc(4'h7, 1'b1, 4'h0, '0, 4'h0, 4'h0, 1'b0);
    chk("exh_free4", {24'd0, fl.o_free_cnt}, 32'd4);
    chk("exh_can1", {31'd0, fl.o_can_alloc}, 32'd1);
    chk("exh_idx", {4'd0, fl.o_alloc_prd_idx}, {4'd0, p4(126,127,9,0)});
    cyc(4'h1, 1'b0, 4'h0, '0, 4'h0, 4'h0, 1'b0);
    chk("exh_last", {4'd0, fl.o_alloc_prd_idx}, {4'd0, p4(10,0,0,0)});
    chk("exh_free1", {24'd0, fl.o_free_cnt}, 32'd1);

    // Squash: 12 allocated, 5 committed, squash together with one more commit.
    do_reset();
    for (int i = 0; i < 3; i++) cyc(4'hF, 1'b1, 4'h0, '0, 4'h0, 4'h0, 1'b0);
    cyc(4'h0, 1'b0, 4'h0, '0, 4'hF, 4'hF, 1'b0);
    cyc(4'h0, 1'b0, 4'h0, '0, 4'h1, 4'h1, 1'b0);
    cyc(4'hF, 1'b0, 4'h0, '0, 4'h1, 4'h1, 1'b1);
    chk("sq_can0", {31'd0, fl.o_can_alloc}, 32'd0);
    chk("sq_free_before", {24'd0, fl.o_free_cnt}, 32'd115);
    cyc(4'hF, 1'b0, 4'h0, '0, 4'h0, 4'h0, 1'b0);
    chk("sq_free_after", {24'd0, fl.o_free_cnt}, 32'd121);
    chk("sq_idx", {4'd0, fl.o_alloc_prd_idx}, {4'd0, p4(7,8,9,10)});
    chk("sq_can1", {31'd0, fl.o_can_alloc}, 32'd1);

    // Reset asserted while a dealloc is active, then sparse request from head 0.
    cyc(4'h0, 1'b0, 4'hF, p4(50,51,52,53), 4'h0, 4'h0, 1'b0);
    rst = 1'b1;
    cyc(4'hF, 1'b0, 4'h0, '0, 4'h0, 4'h0, 1'b0);
    chk("rst_free", {24'd0, fl.o_free_cnt}, 32'd127);
    chk("rst_idx", {4'd0, fl.o_alloc_prd_idx}, {4'd0, p4(1,2,3,4)});
    cyc(4'hA, 1'b1, 4'h0, '0, 4'h0, 4'h0, 1'b0);
    chk("sparse_idx", {4'd0, fl.o_alloc_prd_idx}, {4'd0, p4(0,1,0,2)});
    cyc(4'h0, 1'b0, 4'h0, '0, 4'h0, 4'h0, 1'b0);
    chk("sparse_free", {24'd0, fl.o_free_cnt}, 32'd125);

    // Random run against a FIFO model of the free list; pointers wrap several times.
    do_reset();
    q.delete(); outq.delete();
    for (int i = 1; i < NUM_PHYREG; i++) q.push_back(i);
    pend = 0;
    saw_zero = 1'b0;
    for (int c = 0; c < 300; c++) begin
      r_req = 4'($urandom_range(0, 15));
      rn = 0;
      for (int i = 0; i < 4; i++) rn += int'(r_req[i]);
      mcan = (rn <= q.size());
      r_fire = mcan && ($urandom_range(0, 3) != 0);
      nd = (outq.size() > 40) ? 4 : int'($urandom_range(0, 2));
      if (nd > outq.size()) nd = outq.size();
      r_dvld = '0; r_didx = '0; taken = 0; dv.delete();
      for (int j = 0; j < 4; j++) begin
        if ((nd - taken) > 0 && ((nd - taken) >= (4 - j) || $urandom_range(0, 1) == 1)) begin
          pick = int'($urandom_range(0, outq.size() - 1));
          r_dvld[j] = 1'b1;
          r_didx[j*7 +: 7] = 7'(outq[pick]);
          dv.push_back(outq[pick]);
          outq.delete(pick);
          taken++;
        end
      end
      k = (pend > 60) ? 4 : int'($urandom_range(0, 4));
      if (k > pend) k = pend;
      r_cmask = 4'((1 << k) - 1);
      r_cvld = r_cmask | 4'($urandom_range(0, 15));
      cyc(r_req, r_fire, r_dvld, r_didx, r_cvld, r_cmask, 1'b0);
      pend -= k;
      chk("rnd_can", {31'd0, fl.o_can_alloc}, {31'd0, mcan});
      chk("rnd_free", {24'd0, fl.o_free_cnt}, 32'(q.size()));
      if (mcan) begin
        r_exp = '0; ofs = 0;
        for (int i = 0; i < 4; i++) begin
          if (r_req[i]) begin
            r_exp[i*7 +: 7] = 7'(q[ofs]);
            ofs++;
          end
        end
        chk("rnd_idx", {4'd0, fl.o_alloc_prd_idx}, {4'd0, r_exp});
      end
      if (r_fire) begin
        for (int i = 0; i < 4; i++) begin
          if (r_req[i]) begin
            if (fl.o_alloc_prd_idx[i] == '0) saw_zero = 1'b1;
            outq.push_back(q.pop_front());
          end
        end
        pend += rn;
      end
      foreach (dv[i]) q.push_back(dv[i]);
    end
    cyc(4'h0, 1'b0, 4'h0, '0, 4'h0, 4'h0, 1'b0);
    chk("rnd_free_end", {24'd0, fl.o_free_cnt}, 32'(q.size()));
    chk("rnd_no_zero", {31'd0, saw_zero}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/rename_freelist.md
Name: rename_freelist

Overview:
- Physical-register free list and allocation scheduler for the integer rename stage.
- Hands up to WIDTH free physical indices per cycle to rename slots that write rd, packed by request order.
- Takes back indices released by the RAT commit-dealloc path.
- On squash, rolls the speculative head back to the committed (arch) head, matching the spec/arch RAT restore scheme.

Parameters:
- WIDTH, 4, rename slots per cycle.
- COMMIT_WID, 4, commit/dealloc lanes per cycle.
- NUM_PHYREG, 128, physical registers; must be a power of two. Index 0 is permanently reserved and never enters the list.
- PR_W, $clog2(NUM_PHYREG), physical index width.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; synchronous, active-high.
- i_req_vld  input  WIDTH  per-slot request for a new prd. Clear for mv-eliminated and no-rd slots.
- i_alloc_fire  input  1  rename accepts this cycle's allocation.
- o_can_alloc  output  1  free_cnt >= popcount(i_req_vld) and no squash this cycle.
- o_alloc_prd_idx  output  WIDTH x PR_W  allocated index per slot; 0 for non-requesting slots.
- i_dealloc_vld  input  COMMIT_WID  released-index valid per lane.
- i_dealloc_prd_idx  input  COMMIT_WID x PR_W  released indices.
- i_commit_vld  input  COMMIT_WID  committed instruction per lane.
- i_commit_alloc  input  COMMIT_WID  committed instruction consumed a free-list entry.
- i_squash_vld  input  1  pipeline squash.
- o_free_cnt  output  PR_W+1  speculative free count, registered.

Behaviour:
- Storage: circular array of NUM_PHYREG entries.
- Pointers: spec_head, arch_head, tail; each PR_W+1 bits including a wrap bit. free_cnt = tail - spec_head.
- Reset:
  - entry k = k+1 for k = 0..NUM_PHYREG-2.
  - spec_head = arch_head = 0; tail = NUM_PHYREG-1; o_free_cnt = NUM_PHYREG-1.
  - Cycle after reset: o_can_alloc = 1 and o_alloc_prd_idx = 1..WIDTH when all slots request.
- Allocation (combinational from registered state):
  - Slot i reads entry[spec_head + popcount(i_req_vld[i-1:0])].
  - Packing is in request order; non-requesting slots output 0.
- Allocate: when i_alloc_fire && o_can_alloc, spec_head += popcount(i_req_vld) at the next edge.
- Fire with o_can_alloc = 0 is ignored; assert that it never happens.
- Dealloc:
  - Valid lanes are compacted in lane order and written at tail, tail+1, ...; tail += popcount(i_dealloc_vld).
  - Written entries are visible to allocation from the next cycle. No same-cycle bypass.
- Commit: arch_head += popcount(i_commit_vld & i_commit_alloc).
- Squash:
  - spec_head <= arch_head + this cycle's commit increment.
  - Allocation is suppressed: o_can_alloc = 0 and fire is ignored.
  - Dealloc and commit in the same cycle still take effect.
- Simultaneous alloc, dealloc and commit in one cycle: all applied independently. free_cnt_next = free_cnt - alloc_n + dealloc_n.
- Wrap-around: pointers wrap modulo 2*NUM_PHYREG. Array index is the pointer's low PR_W bits.
- Assertions:
  - Dealloc of index 0 never occurs.
  - free_cnt never exceeds NUM_PHYREG-1.
  - arch_head never passes spec_head, i.e. spec_head - arch_head <= NUM_PHYREG.
- Empty/partial: if free_cnt < popcount(i_req_vld), o_can_alloc = 0. There is no partial allocation; o_alloc_prd_idx still shows the head entries.
- Reset mid-operation: all pointers and array contents return to reset values at the next edge, regardless of other inputs.

Test Plan:
- Reset, i_req_vld=4'b1111, fire -> o_alloc_prd_idx = {1,2,3,4}, o_can_alloc=1; next cycle o_free_cnt=123 and outputs {5,6,7,8}.
- Sparse request: i_req_vld=4'b1010 at spec_head=0, fire -> slot1=1, slot3=2, slots 0 and 2 = 0; free_cnt drops by 2.
- Exhaust: allocate until free_cnt=2, request 3 -> o_can_alloc=0, head unchanged. Then dealloc {9,10} on lanes 0 and 2 -> next cycle free_cnt=4 and a 3-request allocates, ending with 9,10 after remaining entries.
- Squash: allocate 12 entries, commit 5 with i_commit_alloc=1, squash in the same cycle as a commit of 1 more -> spec_head=arch_head=6, free_cnt=121, can_alloc=0 during the squash cycle.
- Wrap: run 300 cycles of random alloc/dealloc with bounded occupancy -> no index is duplicated across outstanding plus free, index 0 never appears, and the pointer wrap bit toggles correctly.
- Reset asserted mid-run with dealloc active -> next cycle free_cnt=127 and outputs {1,2,3,4}.
